// File: rtl/prng_ctrl.sv
// prng_ctrl: UART command sequencer for a Rule-90 PRNG ('S' + 8 seed bytes, 'G' + count).
// Optional inter-byte timeout in SEED/GEN_LEN when PRNG_CTRL_TIMEOUT_EN is defined.
module prng_ctrl #(
    parameter int         STEP_LATENCY   = 2,
    parameter logic [7:0] CMD_SEED       = 8'h53,
    parameter logic [7:0] CMD_GEN        = 8'h47,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_byte,
    input  logic        rx_byte_valid,
    output logic [63:0] prng_data,
    output logic        prng_valid,
    input  logic [1:0]  q_in,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        err
);
    typedef enum logic [2:0] {IDLE, SEED, LOAD, GEN_LEN, STEP, WAIT, SEND} state_t;
    state_t state, state_n;
    logic [63:0] seed, seed_n;
    logic [2:0]  byte_cnt, pair_cnt;
    logic [7:0]  remaining, pack;
    logic [3:0]  wait_cnt;
    logic        seeding, err_n, timeout, wait_done;
    assign seed_n     = {seed[55:0], rx_byte};
    assign wait_done  = wait_cnt == 4'(STEP_LATENCY - 1);
    assign prng_valid = state == LOAD || state == STEP;
    assign tx_valid   = state == SEND;
    assign tx_data    = pack;
    assign busy       = state != IDLE;
`ifdef PRNG_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt;
    logic          in_rx;
    assign in_rx   = state == SEED || state == GEN_LEN;
    assign timeout = in_rx && !rx_byte_valid && idle_cnt == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (!reset || !in_rx || rx_byte_valid || timeout) idle_cnt <= '0;
        else idle_cnt <= idle_cnt + 1'b1;
    end
`else
    logic unused_timeout;
    assign timeout        = 1'b0;
    assign unused_timeout = TIMEOUT_CYCLES[0];
`endif
    always_comb begin
        state_n = state;
        err_n   = 1'b0;
        case (state)
            IDLE: if (rx_byte_valid) begin
                state_n = rx_byte == CMD_SEED ? SEED : rx_byte == CMD_GEN ? GEN_LEN : IDLE;
                err_n   = rx_byte != CMD_SEED && rx_byte != CMD_GEN;
            end
            SEED: if (rx_byte_valid && byte_cnt == 3'd7) begin
                state_n = seed_n != '0 ? LOAD : IDLE;
                err_n   = seed_n == '0;
            end
            LOAD:    state_n = WAIT;
            GEN_LEN: if (rx_byte_valid) state_n = rx_byte != 8'd0 ? STEP : IDLE;
            STEP:    state_n = WAIT;
            WAIT:    if (wait_done) state_n = seeding ? IDLE : pair_cnt == 3'd3 ? SEND : STEP;
            SEND:    if (tx_ready) state_n = remaining == 8'd1 ? IDLE : STEP;
            default: state_n = IDLE;
        endcase
        // Bytes arriving while the PRNG is being driven are dropped, not queued
        if (rx_byte_valid && state inside {LOAD, STEP, WAIT, SEND}) err_n = 1'b1;
        if (timeout) begin
            state_n = IDLE;
            err_n   = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            seed      <= '0;
            byte_cnt  <= '0;
            pair_cnt  <= '0;
            remaining <= '0;
            pack      <= '0;
            wait_cnt  <= '0;
            seeding   <= 1'b0;
            prng_data <= '0;
            err       <= 1'b0;
        end else begin
            state    <= state_n;
            err      <= err_n;
            seeding  <= state == LOAD ? 1'b1 : state == STEP ? 1'b0 : seeding;
            wait_cnt <= state == WAIT && !wait_done ? wait_cnt + 4'd1 : 4'd0;
            if (state_n == LOAD) prng_data <= seed_n;
            else if (state_n == STEP) prng_data <= '0;
            if (state == IDLE) byte_cnt <= '0;
            if (state == SEED && rx_byte_valid) begin
                seed     <= seed_n;
                byte_cnt <= byte_cnt + 3'd1;
            end
            if (state == GEN_LEN && rx_byte_valid) begin
                remaining <= rx_byte;
                pair_cnt  <= '0;
            end
            // First sample of a byte shifts up to bits [7:6]
            if (state == WAIT && wait_done && !seeding) begin
                pack     <= {pack[5:0], q_in};
                pair_cnt <= pair_cnt + 3'd1;
            end
            if (state == SEND && tx_ready) begin
                remaining <= remaining - 8'd1;
                pair_cnt  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_prng_ctrl.sv
// tb_prng_ctrl: bench for prng_ctrl with an emulated Rule-90 core and an arithmetic reference.
module tb_prng_ctrl;
`ifdef PRNG_CTRL_TIMEOUT_EN
    localparam int TO = 100;
`else
    localparam int TO = 1000000;
`endif
    localparam int L = 2;
    logic        clk = 1'b0, reset = 1'b0, rx_byte_valid = 1'b0, tx_ready = 1'b0;
    logic [7:0]  rx_byte = 8'd0;
    logic [63:0] prng_data;
    logic        prng_valid, tx_valid, busy, err;
    logic [1:0]  q_in = 2'd0;
    logic [7:0]  tx_data;
    logic [63:0] core = 64'd0, ref_state = 64'd0, last_pulse_data = 64'd0;
    int          checks = 0, errors = 0, pulses = 0, nz_pulses = 0, errs = 0;
    logic [7:0]  txq[$];

    prng_ctrl #(.STEP_LATENCY(L), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
        .prng_data(prng_data), .prng_valid(prng_valid), .q_in(q_in),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rule90(input logic [63:0] s);
        return (s << 1) ^ (s >> 1);
    endfunction

    // Emulated PRNG core: state updates at the pulse edge, q_in one edge later
    always @(posedge clk) begin
        if (prng_valid) core <= prng_data != 64'd0 ? prng_data : rule90(core);
        q_in <= core[1:0];
    end

    always @(negedge clk) begin
        if (prng_valid) begin
            pulses++;
            if (prng_data != 64'd0) nz_pulses++;
            last_pulse_data = prng_data;
        end
        if (err) errs++;
        if (tx_valid && tx_ready) txq.push_back(tx_data);
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte = b;
        rx_byte_valid = 1'b1;
        tick(1);
        rx_byte_valid = 1'b0;
    endtask

    task automatic load_seed(input logic [63:0] s);
        send_byte(8'h53);
        for (int i = 0; i < 8; i++) send_byte(s[63-8*i -: 8]);
        ref_state = s;
        tick(L + 1);
    endtask

    task automatic next_ref_byte(output logic [7:0] b);
        b = 8'd0;
        for (int i = 0; i < 4; i++) begin
            ref_state = rule90(ref_state);
            b = {b[5:0], ref_state[1:0]};
        end
    endtask

    task automatic wait_bytes(input int target, input int budget, input bit rnd, output bit ok);
        int k = 0;
        while (txq.size() < target && k < budget) begin
            if (rnd) tx_ready = 1'($urandom_range(0, 1));
            tick(1);
            k++;
        end
        ok = txq.size() >= target;
    endtask

    task automatic wait_tx_valid(input int budget, output bit ok);
        int k = 0;
        while (tx_valid !== 1'b1 && k < budget) begin
            tick(1);
            k++;
        end
        ok = tx_valid === 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        tick(3);
        checks++; if (prng_data !== 64'd0) begin errors++; $display("FAIL reset_prng_data got %h exp 0", prng_data); end
        checks++; if (prng_valid !== 1'b0) begin errors++; $display("FAIL reset_prng_valid got %b exp 0", prng_valid); end
        checks++; if (tx_data !== 8'd0) begin errors++; $display("FAIL reset_tx_data got %h exp 0", tx_data); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b exp 0", tx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        reset = 1'b1;
        tick(1);
    endtask

    task automatic test_seed_load;
        logic [63:0] s = 64'h0000000180000000;
        int p0 = pulses, n0 = txq.size();
        send_byte(8'h53);
        for (int i = 0; i < 8; i++) send_byte(s[63-8*i -: 8]);
        checks++; if (prng_valid !== 1'b1) begin errors++; $display("FAIL seed_pulse got %b exp 1", prng_valid); end
        checks++; if (prng_data !== s) begin errors++; $display("FAIL seed_data got %h exp %h", prng_data, s); end
        tick(L);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL seed_busy_hold got %b exp 1", busy); end
        tick(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL seed_busy_drop got %b exp 0", busy); end
        checks++; if (pulses - p0 != 1) begin errors++; $display("FAIL seed_pulse_count got %0d exp 1", pulses - p0); end
        checks++; if (txq.size() != n0) begin errors++; $display("FAIL seed_no_tx got %0d exp %0d", txq.size(), n0); end
        ref_state = s;
    endtask

    task automatic test_generate;
        int p0 = pulses, z0 = nz_pulses, n0 = txq.size();
        bit ok;
        logic [7:0] exp_b;
        tx_ready = 1'b1;
        send_byte(8'h47);
        send_byte(8'd3);
        checks++; if (prng_valid !== 1'b1 || prng_data !== 64'd0) begin errors++; $display("FAIL gen_first_pulse got %b/%h exp 1/0", prng_valid, prng_data); end
        tick(4 * (1 + L) - 1);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL gen_tx_early got %b exp 0", tx_valid); end
        tick(1);
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL gen_tx_latency got %b exp 1", tx_valid); end
        wait_bytes(n0 + 3, 300, 1'b0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL gen_timeout got %0d bytes exp 3", txq.size() - n0); end
        for (int i = 0; i < 3 && n0 + i < txq.size(); i++) begin
            next_ref_byte(exp_b);
            checks++; if (txq[n0+i] !== exp_b) begin errors++; $display("FAIL gen_byte%0d got %h exp %h", i, txq[n0+i], exp_b); end
        end
        tick(2);
        checks++; if (pulses - p0 != 12) begin errors++; $display("FAIL gen_pulse_count got %0d exp 12", pulses - p0); end
        checks++; if (nz_pulses != z0) begin errors++; $display("FAIL gen_step_data got %0d nonzero exp 0", nz_pulses - z0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gen_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_zero_seed;
        int p0 = pulses, e0 = errs;
        send_byte(8'h53);
        repeat (8) send_byte(8'h00);
        tick(L + 2);
        checks++; if (errs - e0 != 1) begin errors++; $display("FAIL zero_seed_err got %0d exp 1", errs - e0); end
        checks++; if (pulses != p0) begin errors++; $display("FAIL zero_seed_pulse got %0d exp 0", pulses - p0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_seed_idle got %b exp 0", busy); end
    endtask

    task automatic test_backpressure;
        int n0 = txq.size(), p0, bad = 0;
        bit ok;
        logic [7:0] d, exp_b;
        tx_ready = 1'b0;
        send_byte(8'h47);
        send_byte(8'd2);
        wait_tx_valid(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_tx_valid got 0 exp 1"); end
        d = tx_data;
        p0 = pulses;
        repeat (50) begin
            tick(1);
            if (tx_valid !== 1'b1 || tx_data !== d) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold got %0d unstable cycles exp 0", bad); end
        checks++; if (pulses != p0) begin errors++; $display("FAIL bp_extra_pulse got %0d exp 0", pulses - p0); end
        tx_ready = 1'b1;
        wait_bytes(n0 + 2, 100, 1'b0, ok);
        tick(5);
        checks++; if (txq.size() - n0 != 2) begin errors++; $display("FAIL bp_count got %0d exp 2", txq.size() - n0); end
        for (int i = 0; i < 2 && n0 + i < txq.size(); i++) begin
            next_ref_byte(exp_b);
            checks++; if (txq[n0+i] !== exp_b) begin errors++; $display("FAIL bp_byte%0d got %h exp %h", i, txq[n0+i], exp_b); end
        end
    endtask

    task automatic test_edge_cases;
        int p0 = pulses, n0 = txq.size(), e0 = errs;
        bit ok;
        logic [7:0] exp_b;
        send_byte(8'h47);
        send_byte(8'd0);
        tick(5);
        checks++; if (pulses != p0 || txq.size() != n0 || busy !== 1'b0) begin errors++; $display("FAIL gen_zero got %0d pulses %0d bytes busy %b exp 0 0 0", pulses - p0, txq.size() - n0, busy); end
        send_byte(8'h41);
        tick(2);
        checks++; if (errs - e0 != 1 || busy !== 1'b0) begin errors++; $display("FAIL bad_cmd got err %0d busy %b exp 1 0", errs - e0, busy); end
        e0 = errs;
        p0 = pulses;
        tx_ready = 1'b1;
        send_byte(8'h47);
        send_byte(8'd1);
        send_byte(8'h53);
        wait_bytes(n0 + 1, 100, 1'b0, ok);
        tick(3);
        next_ref_byte(exp_b);
        checks++; if (!ok || txq[n0] !== exp_b) begin errors++; $display("FAIL overrun_byte got %h exp %h", ok ? txq[n0] : 8'hxx, exp_b); end
        checks++; if (errs - e0 != 1) begin errors++; $display("FAIL overrun_err got %0d exp 1", errs - e0); end
        checks++; if (pulses - p0 != 4) begin errors++; $display("FAIL overrun_pulses got %0d exp 4", pulses - p0); end
    endtask

    task automatic test_reset_mid_send;
        bit ok;
        logic [7:0] junk;
        tx_ready = 1'b0;
        send_byte(8'h47);
        send_byte(8'd1);
        wait_tx_valid(100, ok);
        next_ref_byte(junk);
        reset = 1'b0;
        tick(1);
        checks++; if (!ok || tx_valid !== 1'b0 || tx_data !== 8'd0) begin errors++; $display("FAIL rst_send_tx got %b/%h exp 0/00", tx_valid, tx_data); end
        checks++; if (prng_data !== 64'd0 || prng_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_send_outs got %h %b %b %b exp all 0", prng_data, prng_valid, busy, err); end
        reset = 1'b1;
        tx_ready = 1'b1;
        tick(2);
    endtask

    task automatic test_random_gen;
        for (int it = 0; it < 4; it++) begin
            logic [63:0] s = {$urandom, $urandom};
            int n = $urandom_range(1, 5), n0, p0;
            bit ok;
            logic [7:0] exp_b;
            if (s == 64'd0) s = 64'd1;
            load_seed(s);
            n0 = txq.size();
            p0 = pulses;
            send_byte(8'h47);
            send_byte(8'(n));
            wait_bytes(n0 + n, 2000, 1'b1, ok);
            tx_ready = 1'b1;
            tick(2);
            checks++; if (!ok) begin errors++; $display("FAIL rand%0d_timeout got %0d bytes exp %0d", it, txq.size() - n0, n); end
            for (int i = 0; i < n && n0 + i < txq.size(); i++) begin
                next_ref_byte(exp_b);
                checks++; if (txq[n0+i] !== exp_b) begin errors++; $display("FAIL rand%0d_byte%0d got %h exp %h", it, i, txq[n0+i], exp_b); end
            end
            checks++; if (pulses - p0 != 4 * n) begin errors++; $display("FAIL rand%0d_pulses got %0d exp %0d", it, pulses - p0, 4 * n); end
        end
    endtask

`ifdef PRNG_CTRL_TIMEOUT_EN
    task automatic test_timeout;
        int e0 = errs, p0;
        logic [63:0] s = 64'h0123456789abcdef;
        send_byte(8'h53);
        repeat (3) send_byte(8'h5a);
        tick(TO - 5);
        checks++; if (errs != e0 || busy !== 1'b1) begin errors++; $display("FAIL timeout_early got err %0d busy %b exp 0 1", errs - e0, busy); end
        tick(10);
        checks++; if (errs - e0 != 1 || busy !== 1'b0) begin errors++; $display("FAIL timeout_fire got err %0d busy %b exp 1 0", errs - e0, busy); end
        p0 = pulses;
        load_seed(s);
        checks++; if (pulses - p0 != 1 || last_pulse_data !== s) begin errors++; $display("FAIL timeout_reload got %0d/%h exp 1/%h", pulses - p0, last_pulse_data, s); end
    endtask
`endif

    initial begin
        tick(1);
        test_reset();
        test_seed_load();
        test_generate();
        test_zero_seed();
        test_backpressure();
        test_edge_cases();
        test_reset_mid_send();
        test_random_gen();
`ifdef PRNG_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/prng_ctrl.md
# prng_ctrl

- Command sequencer that sits between the UART receive/transmit byte interfaces and the Rule‑90 PRNG core.
- Parses host commands to load a 64‑bit seed or to generate N output bytes.
- Issues single‑cycle valid pulses to the PRNG and samples its 2‑bit output after a fixed latency.
- Packs four 2‑bit samples into each byte and hands bytes to the UART transmitter with a valid/ready handshake.

## Interface
Parameters:
- STEP_LATENCY, 2: cycles from the PRNG valid-pulse cycle until the updated `q_in` may be sampled (range 1–15).
- CMD_SEED, 8'h53: command byte ('S') for seed load.
- CMD_GEN, 8'h47: command byte ('G') for generate.
- TIMEOUT_CYCLES, 1000000: inter-byte timeout; used only with PRNG_CTRL_TIMEOUT_EN.

Ports:
- clk  input  1  single clock.
- reset  input  1  synchronous, active-low reset.
- rx_byte  input  8  received byte from UART RX.
- rx_byte_valid  input  1  one-cycle strobe; `rx_byte` is valid in that cycle.
- prng_data  output  64  seed/data bus to PRNG `data_in`.
- prng_valid  output  1  one-cycle pulse to PRNG `rx_valid_pulse`.
- q_in  input  2  PRNG output bits [1:0].
- tx_data  output  8  packed output byte.
- tx_valid  output  1  byte available.
- tx_ready  input  1  transmitter accepts; transfer happens when `tx_valid && tx_ready`.
- busy  output  1  high in every state except IDLE.
- err  output  1  one-cycle error pulse.

## Operation
- **Reset values:** all outputs 0; FSM in IDLE; seed shift register, counters and pack register all 0.
- **IDLE:**
  - `rx_byte_valid` with CMD_SEED → SEED, byte counter cleared.
  - CMD_GEN → GEN_LEN.
  - Any other byte → dropped, `err` pulse.
- **SEED:**
  - Each strobed byte shifts into the seed register MSB-first: `seed <= {seed[55:0], rx_byte}`.
  - After the 8th byte: nonzero seed → LOAD; zero seed → `err` pulse and return to IDLE with no PRNG pulse. The PRNG treats zero as a step, so a zero seed is rejected.
- **LOAD:**
  - One cycle: `prng_data = seed`, `prng_valid = 1`.
  - Then WAIT for STEP_LATENCY cycles, then IDLE.
- **GEN_LEN:**
  - Next strobed byte is count N (0–255).
  - N = 0 → IDLE with no activity.
  - Otherwise load remaining = N, pair counter = 0, → STEP.
- **STEP:**
  - One cycle: `prng_data = 64'd0`, `prng_valid = 1`. Zero data makes the PRNG advance one Rule‑90 step.
  - → WAIT.
- **WAIT:**
  - Count STEP_LATENCY cycles, then sample: `pack <= {pack[5:0], q_in}`.
  - First sample ends up in bits [7:6].
  - Pair counter increments. If pair counter reaches 4 → SEND, otherwise → STEP.
- **SEND:**
  - `tx_data = pack`, `tx_valid = 1`, held stable until `tx_ready`.
  - On transfer: remaining decrements, pair counter clears.
  - remaining reaches 0 → IDLE; otherwise → STEP.
- **Overrun:** `rx_byte_valid` in LOAD, STEP, WAIT or SEND drops the byte and pulses `err`; the FSM is unaffected.
- **Output hold:** `prng_data` is registered and holds its last value outside LOAD and STEP.

## Timing
- **PRNG pulse:** `prng_valid` is high exactly one cycle per LOAD/STEP visit; `prng_data` is valid in that same cycle.
- **Sample point:** with the pulse in cycle P, `q_in` is sampled at the clock edge ending cycle P+STEP_LATENCY.
- **GEN latency:** count byte strobed in cycle T → first `prng_valid` in T+1.
- **Per-byte cost:** 4×(1+STEP_LATENCY) cycles plus handshake. With default parameters, the first `tx_valid` rises in cycle T+13.
- **SEED latency:** 8th seed byte in cycle T → `prng_valid` in T+1 → `busy` low from T+2+STEP_LATENCY.
- **Back-to-back transfer:** `tx_valid` may drop the cycle after transfer. Minimum gap between bytes is 4×(1+STEP_LATENCY) cycles.
- **Reset mid-operation:** asserting `reset` at any edge returns to IDLE at that edge. `tx_valid` drops without a handshake and any partial seed or count is discarded.
- **`err` priority:** when an overrun and a zero-seed rejection coincide, `err` is a single one-cycle pulse.

## Configuration
- **With `PRNG_CTRL_TIMEOUT_EN` defined:**
  - A counter runs in SEED and GEN_LEN and is cleared on each strobed byte.
  - Reaching TIMEOUT_CYCLES → `err` pulse and return to IDLE, discarding partial input.
- **Without it:** SEED and GEN_LEN wait indefinitely and the counter logic is absent.

## Test plan
- **Seed load:** send 'S' then bytes 00 00 00 01 80 00 00 00 → one `prng_valid` with `prng_data = 64'h0000000180000000`; `busy` low STEP_LATENCY+1 cycles after the pulse; no `tx_valid`.
- **Zero seed:** send 'S' plus eight 00 bytes → `err` pulse, no `prng_valid`, FSM in IDLE.
- **Generate against behavioral PRNG model:** seed as in the seed-load test, then 'G' 03 → exactly 12 `prng_valid` pulses with `prng_data = 0`. The 3 bytes must equal the model's bit pairs packed MSB-first, with `tx_ready` held high.
- **Backpressure:** 'G' 02 with `tx_ready` low for 50 cycles → `tx_valid` and `tx_data` held stable, no extra `prng_valid` until transfer; exactly 2 bytes delivered.
- **Edge cases:** 'G' 00 → no pulses, no `tx_valid`. Byte 0x41 in IDLE → `err`. Byte during STEP/WAIT → `err` with generation uninterrupted. Reset asserted mid-SEND → all outputs 0 on the next cycle.
- **Timeout (with `PRNG_CTRL_TIMEOUT_EN`, TIMEOUT_CYCLES = 100):** 'S' plus 3 bytes, then idle → `err` after 100 cycles. A subsequent valid 'S' sequence then loads correctly.
